// File: rtl/uproc_mem_pkg.sv
// Shared types and widths for the unified instruction/data memory path.
// The fetch and MEM stages import the same widths so their buses match the arbiter.
package uproc_mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data ports, with a streak counter that
// stops a busy data port from starving instruction fetch.
module mem_arb_pick
    import uproc_mem_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant,
    output logic winner
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    logic [SW-1:0] streak_reg;

    always_comb begin
        winner = PORT_IF;
        if (dm_req && !(if_req && streak_reg == STREAK_MAX))
            winner = PORT_DM;
    end

    // The streak only grows while fetch is actually waiting behind the data port.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            streak_reg <= '0;
        end else if (grant) begin
            if (winner == PORT_DM && if_req) begin
                if (streak_reg != STREAK_MAX)
                    streak_reg <= streak_reg + 1'b1;
            end else begin
                streak_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Sequences the single-port unified memory between instruction fetch and data
// access: one access at a time, IDLE -> ISSUE -> WAIT(MEM_LAT) -> IDLE.
module unified_mem_arbiter
    import uproc_mem_pkg::*;
#(
    parameter int ADDR_W        = MEM_ADDR_W,
    parameter int DATA_W        = MEM_DATA_W,
    parameter int MEM_DEPTH     = 128,
    parameter int MEM_LAT       = 1,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    arb_state_t    state_reg;
    logic [CW-1:0] lat_cnt_reg;
    logic          sel_port_reg;
    logic          sel_we_reg;
    logic          sel_oor_reg;

    logic              grant;
    logic              winner;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic              req_oor;

    assign grant    = (state_reg == IDLE) && (if_req || dm_req);
    assign req_addr = (winner == PORT_DM) ? dm_addr : if_addr;
    assign req_we   = (winner == PORT_DM) && dm_we;
    assign req_oor  = {1'b0, req_addr} >= DEPTH_L;

    mem_arb_pick #(
        .MAX_DM_STREAK(MAX_DM_STREAK)
    ) u_pick (
        .CLOCK_50(CLOCK_50),
        .RESET   (RESET),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .grant   (grant),
        .winner  (winner)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg    <= IDLE;
            lat_cnt_reg  <= '0;
            sel_port_reg <= PORT_IF;
            sel_we_reg   <= 1'b0;
            sel_oor_reg  <= 1'b0;
            if_gnt       <= 1'b0;
            if_rvalid    <= 1'b0;
            if_rdata     <= '0;
            dm_gnt       <= 1'b0;
            dm_rvalid    <= 1'b0;
            dm_rdata     <= '0;
            addr_err     <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            addr_err  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        state_reg    <= ISSUE;
                        busy         <= 1'b1;
                        sel_port_reg <= winner;
                        sel_we_reg   <= req_we;
                        sel_oor_reg  <= req_oor;
                        if_gnt       <= (winner == PORT_IF);
                        dm_gnt       <= (winner == PORT_DM);
                        mem_en       <= !req_oor;
                        mem_we       <= req_we && !req_oor;
                        mem_addr     <= req_addr;
                        if (winner == PORT_DM)
                            mem_wdata <= dm_wdata;
                    end
                end
                ISSUE: begin
                    state_reg   <= WAIT;
                    lat_cnt_reg <= CW'(MEM_LAT - 1);
                end
                WAIT: begin
                    // Read data is sampled on the final WAIT edge, MEM_LAT cycles after mem_en.
                    if (lat_cnt_reg == '0) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        addr_err  <= sel_oor_reg;
                        if (sel_port_reg == PORT_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= sel_oor_reg ? '0 : mem_rdata;
                        end else begin
                            dm_rvalid <= 1'b1;
                            if (!sel_we_reg)
                                dm_rdata <= sel_oor_reg ? '0 : mem_rdata;
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at MEM_LAT=1 for the
// access/arbitration cases, one at MEM_LAT=3 for reset during WAIT.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance 1: MEM_LAT = 1 ----------------
    logic        rst1;
    logic        if_req, if_gnt, if_rvalid;
    logic [7:0]  if_addr;
    logic [15:0] if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [7:0]  dm_addr;
    logic [15:0] dm_wdata, dm_rdata;
    logic        addr_err, mem_en, mem_we, busy;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] mem1 [0:255];

    unified_mem_arbiter #(.MEM_LAT(1)) u_dut (
        .CLOCK_50(clk), .RESET(rst1),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .addr_err(addr_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Read-first single-port memory with one cycle of read latency.
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem1[i] = '0;
        mem1[8]  = 16'h1A3F;
        mem1[9]  = 16'h0055;
        mem1[10] = 16'h0A0A;
        mem1[20] = 16'h1234;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                mem_rdata <= mem1[mem_addr];
                if (mem_we) mem1[mem_addr] = mem_wdata;
            end
        end
    end

    // ---------------- instance 3: MEM_LAT = 3 ----------------
    logic        rst3;
    logic        if_req3, if_gnt3, if_rvalid3;
    logic [7:0]  if_addr3;
    logic [15:0] if_rdata3;
    logic        dm_req3 = 1'b0, dm_we3 = 1'b0;
    logic [7:0]  dm_addr3 = 8'd0;
    logic [15:0] dm_wdata3 = 16'd0;
    logic        dm_gnt3, dm_rvalid3, addr_err3, mem_en3, mem_we3, busy3;
    logic [15:0] dm_rdata3, mem_wdata3, mem_rdata3;
    logic [7:0]  mem_addr3;
    logic [15:0] mem3 [0:255];
    logic [15:0] pipe3_a, pipe3_b;

    unified_mem_arbiter #(.MEM_LAT(3)) u_dut3 (
        .CLOCK_50(clk), .RESET(rst3),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
        .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
        .addr_err(addr_err3), .mem_en(mem_en3), .mem_we(mem_we3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .busy(busy3)
    );

    initial begin
        pipe3_a = '0; pipe3_b = '0; mem_rdata3 = '0;
        for (int i = 0; i < 256; i++) mem3[i] = '0;
        mem3[8] = 16'h7777;
        forever begin
            @(posedge clk);
            if (mem_en3) pipe3_a <= mem3[mem_addr3];
            pipe3_b    <= pipe3_a;
            mem_rdata3 <= pipe3_b;
            if (mem_en3 && mem_we3) mem3[mem_addr3] = mem_wdata3;
        end
    end

    // Invariants on instance 1 plus one line per completed transaction.
    always @(negedge clk) begin
        if (!rst1) begin
            check("gnt_exclusive", 32'(if_gnt & dm_gnt), 32'd0);
            if (mem_en) check("mem_en_only_issue", 32'(if_gnt | dm_gnt), 32'd1);
            if (if_rvalid) $display("txn IF rdata=%h err=%b", if_rdata, addr_err);
            if (dm_rvalid) $display("txn DM rdata=%h err=%b", dm_rdata, addr_err);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    logic [9:0] pat;
    int         ng;
    logic       rv_seen;

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        if_req3 = 0; if_addr3 = 0;
        repeat (3) tick();
        check("rst_ctrl", 32'({busy, if_gnt, dm_gnt, if_rvalid, dm_rvalid, addr_err, mem_en, mem_we}), 32'd0);
        check("rst_rdata", {if_rdata, dm_rdata}, 32'd0);
        check("rst_membus", 32'({mem_addr, mem_wdata}), 32'd0);
        rst1 = 1'b0; rst3 = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Lone IF read of mem[8].
        if_req = 1; if_addr = 8'd8;
        tick();
        check("if_gnt_c1", 32'({if_gnt, dm_gnt, mem_en, mem_we, busy}), 32'b10101);
        check("if_mem_addr", 32'(mem_addr), 32'd8);
        if_req = 0;
        tick();
        check("if_c2_quiet", 32'({if_gnt, if_rvalid}), 32'd0);
        tick();
        check("if_rvalid_c3", 32'({if_rvalid, dm_rvalid, addr_err}), 32'b100);
        check("if_rdata", 32'(if_rdata), 32'h1A3F);
        tick();
        check("if_rvalid_pulse", 32'({if_rvalid, busy}), 32'd0);

        // Store BEEF to 20, then load it back.
        dm_req = 1; dm_we = 1; dm_addr = 8'd20; dm_wdata = 16'hBEEF;
        tick();
        check("st_issue", 32'({dm_gnt, if_gnt, mem_en, mem_we}), 32'b1011);
        check("st_mem_bus", 32'({mem_addr, mem_wdata}), 32'h14BEEF);
        dm_req = 0; dm_we = 0;
        tick();
        tick();
        check("st_ack", 32'({dm_rvalid, if_rvalid}), 32'b10);
        check("st_rdata_held", 32'(dm_rdata), 32'd0);
        dm_req = 1; dm_addr = 8'd20;
        tick();
        check("ld_issue", 32'({dm_gnt, mem_en, mem_we}), 32'b110);
        dm_req = 0;
        tick();
        tick();
        check("ld_rvalid", 32'(dm_rvalid), 32'd1);
        check("ld_rdata", 32'(dm_rdata), 32'hBEEF);

        // Collision: DM wins first, IF follows at the next arbitration.
        if_req = 1; if_addr = 8'd8; dm_req = 1; dm_addr = 8'd20;
        tick();
        check("col_first", 32'({dm_gnt, if_gnt}), 32'b10);
        dm_req = 0;
        tick();
        check("col_wait", 32'(if_gnt), 32'd0);
        tick();
        check("col_dm_rvalid", 32'({dm_rvalid, if_gnt}), 32'b10);
        check("col_dm_rdata", 32'(dm_rdata), 32'hBEEF);
        tick();
        check("col_second", 32'({if_gnt, dm_gnt}), 32'b10);
        if_req = 0;
        tick();
        tick();
        check("col_if_rvalid", 32'(if_rvalid), 32'd1);
        check("col_if_rdata", 32'(if_rdata), 32'h1A3F);

        // Starvation guard: DM x4, IF, then the streak restarts.
        pat = 10'b0111101111;
        ng = 0;
        dm_req = 1; dm_addr = 8'd9; if_req = 1; if_addr = 8'd10;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            tick();
            if (if_gnt || dm_gnt) begin
                check($sformatf("streak_g%0d", ng), 32'(dm_gnt), 32'(pat[ng]));
                ng++;
            end
        end
        check("streak_grants", ng, 32'd10);
        dm_req = 0; if_req = 0;
        repeat (4) tick();
        check("streak_drained", 32'(busy), 32'd0);
        check("streak_last_if", 32'(if_rdata), 32'h0A0A);
        check("streak_last_dm", 32'(dm_rdata), 32'h0055);

        // Out-of-range load at 200.
        dm_req = 1; dm_addr = 8'd200;
        tick();
        check("oor_issue", 32'({dm_gnt, mem_en}), 32'b10);
        dm_req = 0;
        tick();
        check("oor_wait", 32'(mem_en), 32'd0);
        tick();
        check("oor_resp", 32'({dm_rvalid, addr_err}), 32'b11);
        check("oor_rdata", 32'(dm_rdata), 32'd0);
        tick();
        check("oor_err_pulse", 32'(addr_err), 32'd0);

        // Reset in WAIT on the MEM_LAT=3 instance.
        if_req3 = 1; if_addr3 = 8'd8;
        tick();
        check("r3_gnt", 32'(if_gnt3), 32'd1);
        if_req3 = 0;
        tick();
        check("r3_busy_wait", 32'(busy3), 32'd1);
        #2 rst3 = 1'b1;
        #1 check("r3_busy_reset", 32'({busy3, if_rvalid3}), 32'd0);
        #2 rst3 = 1'b0;
        rv_seen = 1'b0;
        repeat (6) begin
            tick();
            rv_seen = rv_seen | if_rvalid3;
        end
        check("r3_no_rvalid", 32'(rv_seen), 32'd0);
        check("r3_rdata_clr", 32'(if_rdata3), 32'd0);
        if_req3 = 1; if_addr3 = 8'd8;
        tick();
        check("r3_regnt", 32'(if_gnt3), 32'd1);
        if_req3 = 0;
        repeat (3) tick();
        check("r3_not_yet", 32'(if_rvalid3), 32'd0);
        tick();
        check("r3_rvalid", 32'(if_rvalid3), 32'd1);
        check("r3_rdata", 32'(if_rdata3), 32'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
